// File: rtl/regfile_sb_if.sv
// Bundle between the ID/WB pipeline side and the architectural register file.
// The master drives writeback, read requests and issue; the slave returns read data and hazards.
interface regfile_sb_if #(
  parameter int unsigned REG_W  = 32,
  parameter int unsigned ADDR_W = 5
) ();
  logic              rdy;
  logic              wb_rd_enable;
  logic [ADDR_W-1:0] wb_rd_addr;
  logic [REG_W-1:0]  wb_rd_data;
  logic              rs1_enable;
  logic [ADDR_W-1:0] rs1_addr;
  logic [REG_W-1:0]  rs1_data;
  logic              rs1_busy;
  logic              rs2_enable;
  logic [ADDR_W-1:0] rs2_addr;
  logic [REG_W-1:0]  rs2_data;
  logic              rs2_busy;
  logic              issue_enable;
  logic [ADDR_W-1:0] issue_rd_addr;
  logic              issue_full;
  logic              stall_req;

  modport master (
    output rdy,
    output wb_rd_enable, wb_rd_addr, wb_rd_data,
    output rs1_enable, rs1_addr, rs2_enable, rs2_addr,
    output issue_enable, issue_rd_addr,
    input  rs1_data, rs1_busy, rs2_data, rs2_busy,
    input  issue_full, stall_req
  );

  modport slave (
    input  rdy,
    input  wb_rd_enable, wb_rd_addr, wb_rd_data,
    input  rs1_enable, rs1_addr, rs2_enable, rs2_addr,
    input  issue_enable, issue_rd_addr,
    output rs1_data, rs1_busy, rs2_data, rs2_busy,
    output issue_full, stall_req
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with writeback bypass on two read ports and a per-register
// pending-write scoreboard that drives the ID-stage busy/stall signals.
module regfile_sb #(
  parameter int unsigned REG_W  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PEND_W = 2
) (
  input logic          clk,
  input logic          rst,
  regfile_sb_if.slave  rf_io
);

  localparam int unsigned NumRegs = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] PendMax = '1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [REG_W-1:0]  data_t;
  typedef logic [PEND_W-1:0] pend_t;

  data_t regs_q [NumRegs];
  data_t regs_d [NumRegs];
  pend_t pend_q [NumRegs];
  pend_t pend_d [NumRegs];

  logic  wb_hit;
  logic  wb_retire;
  logic  issue_nz;
  logic  issue_same_wb;
  logic  issue_full;
  logic  issue_inc;

  logic  rs_en   [2];
  addr_t rs_addr [2];
  data_t rs_data [2];
  logic  rs_busy [2];

  assign rs_en[0]   = rf_io.rs1_enable;
  assign rs_en[1]   = rf_io.rs2_enable;
  assign rs_addr[0] = rf_io.rs1_addr;
  assign rs_addr[1] = rf_io.rs2_addr;

  // A writeback only retires a scoreboard entry when one is outstanding.
  assign wb_hit        = rf_io.wb_rd_enable && (rf_io.wb_rd_addr != '0);
  assign wb_retire     = wb_hit && (pend_q[rf_io.wb_rd_addr] != '0);
  assign issue_nz      = rf_io.issue_rd_addr != '0;
  assign issue_same_wb = wb_retire && (rf_io.wb_rd_addr == rf_io.issue_rd_addr);

  // A saturated counter that retires this cycle has room for the new issue.
  assign issue_full = issue_nz && (pend_q[rf_io.issue_rd_addr] == PendMax) && !issue_same_wb;
  assign issue_inc  = rf_io.issue_enable && issue_nz && !issue_full;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = '0;
      rs_busy[p] = 1'b0;
      if (rs_en[p] && (rs_addr[p] != '0)) begin
        if (rf_io.wb_rd_enable && (rf_io.wb_rd_addr == rs_addr[p])) begin
          rs_data[p] = rf_io.wb_rd_data;
        end else begin
          rs_data[p] = regs_q[rs_addr[p]];
        end
        // Busy drops when this cycle's writeback retires the last outstanding write.
        rs_busy[p] = (pend_q[rs_addr[p]] != '0) &&
                     !((pend_q[rs_addr[p]] == pend_t'(1)) && wb_retire &&
                       (rf_io.wb_rd_addr == rs_addr[p]));
      end
    end
  end

  assign rf_io.rs1_data   = rs_data[0];
  assign rf_io.rs1_busy   = rs_busy[0];
  assign rf_io.rs2_data   = rs_data[1];
  assign rf_io.rs2_busy   = rs_busy[1];
  assign rf_io.issue_full = issue_full;
  assign rf_io.stall_req  = rs_busy[0] || rs_busy[1] || (rf_io.issue_enable && issue_full);

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (rf_io.rdy) begin
      if (wb_hit) begin
        regs_d[rf_io.wb_rd_addr] = rf_io.wb_rd_data;
      end
      // Issue and retire on the same register cancel out.
      if (issue_inc && !issue_same_wb) begin
        pend_d[rf_io.issue_rd_addr] = pend_q[rf_io.issue_rd_addr] + pend_t'(1);
      end
      if (wb_retire && !(issue_inc && issue_same_wb)) begin
        pend_d[rf_io.wb_rd_addr] = pend_q[rf_io.wb_rd_addr] - pend_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NumRegs; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb, checked against an array-based
// model of architectural register contents and outstanding-write counts.
module tb_regfile_sb;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PEND_W = 2;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned PMAX   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.REG_W(REG_W), .ADDR_W(ADDR_W)) rf_if ();

  regfile_sb #(.REG_W(REG_W), .ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .rf_io (rf_if.slave)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [31:0] m_regs [NREGS];
  int unsigned m_pend [NREGS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic rdy, input logic wb_en, input int unsigned wb_a,
                        input logic [31:0] wb_d, input logic r1_en, input int unsigned r1_a,
                        input logic r2_en, input int unsigned r2_a,
                        input logic is_en, input int unsigned is_a);
    rf_if.rdy           = rdy;
    rf_if.wb_rd_enable  = wb_en;
    rf_if.wb_rd_addr    = 5'(wb_a);
    rf_if.wb_rd_data    = wb_d;
    rf_if.rs1_enable    = r1_en;
    rf_if.rs1_addr      = 5'(r1_a);
    rf_if.rs2_enable    = r2_en;
    rf_if.rs2_addr      = 5'(r2_a);
    rf_if.issue_enable  = is_en;
    rf_if.issue_rd_addr = 5'(is_a);
  endtask

  // Outstanding writes on a register once this cycle's writeback (if any) has landed.
  function automatic int unsigned left_after_wb(input int unsigned a);
    int unsigned n = m_pend[a];
    if (rf_if.wb_rd_enable && int'(rf_if.wb_rd_addr) == a && n > 0) n = n - 1;
    return n;
  endfunction

  function automatic logic exp_full();
    int unsigned a = rf_if.issue_rd_addr;
    if (a == 0) return 1'b0;
    return left_after_wb(a) == PMAX;
  endfunction

  function automatic logic exp_busy(input logic en, input int unsigned a);
    if (!en || a == 0) return 1'b0;
    return left_after_wb(a) != 0;
  endfunction

  function automatic logic [31:0] exp_data(input logic en, input int unsigned a);
    if (!en || a == 0) return 32'h0;
    if (rf_if.wb_rd_enable && int'(rf_if.wb_rd_addr) == a) return rf_if.wb_rd_data;
    return m_regs[a];
  endfunction

  task automatic settle_check();
    logic b1, b2, fl;
    #1;
    b1 = exp_busy(rf_if.rs1_enable, rf_if.rs1_addr);
    b2 = exp_busy(rf_if.rs2_enable, rf_if.rs2_addr);
    fl = exp_full();
    check_eq("rs1_data", rf_if.rs1_data, exp_data(rf_if.rs1_enable, rf_if.rs1_addr));
    check_eq("rs2_data", rf_if.rs2_data, exp_data(rf_if.rs2_enable, rf_if.rs2_addr));
    check_eq("rs1_busy", 32'(rf_if.rs1_busy), 32'(b1));
    check_eq("rs2_busy", 32'(rf_if.rs2_busy), 32'(b2));
    check_eq("issue_full", 32'(rf_if.issue_full), 32'(fl));
    check_eq("stall_req", 32'(rf_if.stall_req), 32'(b1 | b2 | (rf_if.issue_enable & fl)));
  endtask

  task automatic tick();
    int unsigned wa, ia;
    logic accept, retire;
    @(posedge clk);
    wa = rf_if.wb_rd_addr;
    ia = rf_if.issue_rd_addr;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = 32'h0;
        m_pend[r] = 0;
      end
    end else if (rf_if.rdy) begin
      accept = rf_if.issue_enable && ia != 0 && !exp_full();
      retire = rf_if.wb_rd_enable && wa != 0 && m_pend[wa] != 0;
      if (rf_if.wb_rd_enable && wa != 0) m_regs[wa] = rf_if.wb_rd_data;
      if (accept) m_pend[ia] = m_pend[ia] + 1;
      if (retire) m_pend[wa] = m_pend[wa] - 1;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state: everything reads back zero and idle.
    set_in(1, 0, 0, 0, 1, 5, 1, 31, 1, 9);
    #1;
    check_eq("rst_rs1_data", rf_if.rs1_data, 32'h0);
    check_eq("rst_rs2_data", rf_if.rs2_data, 32'h0);
    check_eq("rst_full", 32'(rf_if.issue_full), 32'h0);
    set_in(1, 0, 0, 0, 1, 5, 1, 31, 0, 0);
    cycle();

    // Write then read, and x0 stays zero.
    set_in(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    cycle();
    set_in(1, 1, 0, 32'h1234, 1, 5, 0, 0, 0, 0);
    settle_check();
    check_eq("x5_read", rf_if.rs1_data, 32'hDEADBEEF);
    check_eq("x5_busy", 32'(rf_if.rs1_busy), 32'h0);
    tick();
    set_in(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    settle_check();
    check_eq("x0_read", rf_if.rs1_data, 32'h0);
    tick();

    // Bypass, then the stored value next cycle.
    set_in(1, 1, 7, 32'hA5A5A5A5, 0, 0, 1, 7, 0, 0);
    settle_check();
    check_eq("bypass_rs2", rf_if.rs2_data, 32'hA5A5A5A5);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    settle_check();
    check_eq("x7_stored", rf_if.rs2_data, 32'hA5A5A5A5);
    tick();

    // Scoreboard: issue, busy, retire with bypass.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    cycle();
    set_in(1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    settle_check();
    check_eq("x3_busy", 32'(rf_if.rs1_busy), 32'h1);
    check_eq("x3_stall", 32'(rf_if.stall_req), 32'h1);
    tick();
    set_in(1, 1, 3, 32'h10, 1, 3, 0, 0, 0, 0);
    settle_check();
    check_eq("x3_retire_busy", 32'(rf_if.rs1_busy), 32'h0);
    check_eq("x3_retire_data", rf_if.rs1_data, 32'h10);
    tick();
    set_in(1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    settle_check();
    check_eq("x3_idle_busy", 32'(rf_if.rs1_busy), 32'h0);
    tick();

    // Saturation of x9.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 9);
      cycle();
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    settle_check();
    check_eq("x9_full", 32'(rf_if.issue_full), 32'h1);
    check_eq("x9_full_stall", 32'(rf_if.stall_req), 32'h1);
    tick();
    set_in(1, 1, 9, 32'h99, 0, 0, 0, 0, 1, 9);
    settle_check();
    check_eq("x9_issue_retire", 32'(rf_if.issue_full), 32'h0);
    tick();
    set_in(1, 0, 0, 0, 1, 9, 0, 0, 1, 9);
    settle_check();
    check_eq("x9_still_full", 32'(rf_if.issue_full), 32'h1);
    tick();

    // rdy freeze on x4.
    set_in(0, 1, 4, 32'h55, 1, 4, 0, 0, 1, 4);
    settle_check();
    check_eq("frz_bypass", rf_if.rs1_data, 32'h55);
    tick();
    set_in(1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    settle_check();
    check_eq("frz_data", rf_if.rs1_data, 32'h0);
    check_eq("frz_busy", 32'(rf_if.rs1_busy), 32'h0);
    tick();

    // Mid-operation reset with in-flight writes to x2.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_in(1, 1, 2, 32'h7, 1, 2, 1, 5, 0, 0);
    settle_check();
    check_eq("mrst_busy", 32'(rf_if.rs1_busy), 32'h0);
    check_eq("mrst_x5_clear", rf_if.rs2_data, 32'h0);
    tick();
    set_in(1, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    settle_check();
    check_eq("mrst_x2", rf_if.rs1_data, 32'h7);
    check_eq("mrst_x2_busy", 32'(rf_if.rs1_busy), 32'h0);
    tick();

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 9) != 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom(),
             $urandom_range(0, 5) != 0, $urandom_range(0, 7),
             $urandom_range(0, 5) != 0, $urandom_range(0, 7),
             $urandom_range(0, 1) != 0, $urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Architectural integer register file that consumes the writeback interface: wb_rd_enable, wb_rd_addr and wb_rd_data from the MEM/WB pipeline register.
- Serves two combinational read ports to the decode (ID) stage, with write-through bypass of the same-cycle writeback.
- Contains a per-register pending-write scoreboard. ID increments it at issue and writeback decrements it. It produces the busy/stall indications used by the hazard logic.

Parameters:
- REG_W, 32, data width of each register (matches RegLen).
- ADDR_W, 5, register address width (matches RegAddrLen); the file has 2**ADDR_W entries.
- PEND_W, 2, width of each pending-write counter; maximum in-flight writes per register = 2**PEND_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global ready; when low, all state is frozen
- wb_rd_enable  in  1  writeback valid
- wb_rd_addr  in  ADDR_W  writeback destination
- wb_rd_data  in  REG_W  writeback value
- rs1_enable  in  1  read port 1 request
- rs1_addr  in  ADDR_W  read port 1 address
- rs1_data  out  REG_W  read port 1 value (combinational)
- rs1_busy  out  1  rs1 has an outstanding write not yet visible
- rs2_enable  in  1  read port 2 request
- rs2_addr  in  ADDR_W  read port 2 address
- rs2_data  out  REG_W  read port 2 value (combinational)
- rs2_busy  out  1  rs2 has an outstanding write not yet visible
- issue_enable  in  1  ID issues an instruction that will write rd
- issue_rd_addr  in  ADDR_W  destination of the issued instruction
- issue_full  out  1  pending counter of issue_rd_addr is saturated; issue is refused
- stall_req  out  1  rs1_busy | rs2_busy | (issue_enable & issue_full)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, all registers clear to 0 and all pending counters clear to 0. Reset overrides rdy and any simultaneous writeback or issue.
- x0: reads always return 0. Writes to x0 are discarded. Issue to x0 never changes a counter; rs busy is never asserted for x0; issue_full is 0 for x0.
- Write: on posedge with rdy=1, wb_rd_enable=1 and wb_rd_addr!=0, regs[wb_rd_addr] <= wb_rd_data.
- Read (combinational, 0-cycle latency):
  - rsN_enable=0 -> rsN_data=0 and rsN_busy=0.
  - addr==0 -> rsN_data=0.
  - Same-cycle writeback (wb_rd_enable=1, addr==wb_rd_addr) -> rsN_data=wb_rd_data (bypass).
  - Otherwise rsN_data=regs[addr].
  - Bypass applies regardless of rdy.
- Scoreboard counters pend[r], PEND_W bits, updated only on posedge with rdy=1:
  - inc = issue_enable & issue_rd_addr!=0 & !issue_full
  - dec = wb_rd_enable & wb_rd_addr!=0 & pend[wb_rd_addr]!=0
  - inc and dec on different regs: each applied independently.
  - inc and dec on the same reg in the same cycle: counter unchanged.
  - dec when the counter is already 0: counter stays 0. This is a writeback with no matching issue, e.g. after reset; it is not an error.
  - issue_full = (pend[issue_rd_addr] == all-ones), evaluated after accounting for a same-cycle dec on that reg. If the reg is full and is also retiring this cycle, the issue is accepted.
- Busy: rsN_busy = rsN_enable & addr!=0 & pend[addr]!=0, except:
  - busy is deasserted when the same-cycle writeback retires the last outstanding write, i.e. pend[addr]==1 and a dec hits addr. The bypass then provides the value.
- rdy=0: no register writes and no counter updates; combinational outputs still track their inputs.
- Reset mid-operation: counters are cleared, so in-flight writebacks arriving after reset still write the register file but do not decrement (saturate at 0).

Test Plan:
- Reset then read: after rst, write x5=0xDEADBEEF, then read rs1=x5 the next cycle -> rs1_data=0xDEADBEEF, rs1_busy=0. Reading x0 after a write of 0x1234 to x0 -> 0.
- Bypass: in the same cycle, drive wb x7=0xA5A5A5A5 and rs2_addr=7 -> rs2_data=0xA5A5A5A5 while regs[7] is still old. The next cycle regs[7] shows the new value.
- Scoreboard: issue x3; next cycle rs1=x3 -> rs1_busy=1, stall_req=1. Writeback x3=0x10 -> in that cycle busy=0 and rs1_data=0x10; the counter returns to 0.
- Saturation: issue x9 three times (PEND_W=2) -> pend=3. A fourth issue -> issue_full=1, stall_req=1, counter stays 3. Simultaneous issue+retire of x9 -> accepted, counter stays 3.
- rdy freeze: rdy=0 with wb x4=0x55 and issue x4 -> regs[4] and pend[4] are unchanged after the edge. rs1_data on x4 still bypasses 0x55 combinationally.
- Mid-operation reset: issue x2 twice, assert rst -> pend[2]=0 and regs cleared. A subsequent wb x2=0x7 -> regs[2]=0x7, pend[2] stays 0, busy=0.
